qdrc_phy_sequencer: RTL and testbench
=====================================

// Module: qdrc_phy_sequencer
// PURPOSE
//  Top-level calibration sequencer of the QDR PHY, directly upstream of the burst-align stage.
//  After DLL release it runs bit alignment, then burst alignment, and reports PHY ready or fail.
//  Drives each stage's start pulse and consumes its done/fail.
//  Its phy_rdy output gates user traffic onto the QDR bus.
// PARAMETERS
//  DLL_WAIT_CYCLES  2048   clk cycles to hold after qdr_dll_off_n rises before training (>=1024 per QDR II)
//  TIMEOUT_CYCLES   65536  max clk cycles spent in any *_WAIT state before declaring failure (>=2)
//  CNT_WIDTH        17     width of shared counter; must hold max(DLL_WAIT_CYCLES, TIMEOUT_CYCLES)
// PORTS
//  clk                input   1  PHY clock; single domain
//  reset              input   1  synchronous, active-high
//  phy_start          input   1  begin calibration; sampled only in IDLE
//  qdr_dll_off_n      output  1  QDR DLL enable; low = DLL off
//  bit_align_start    output  1  one-cycle pulse to bit-align stage
//  bit_align_done     input   1  bit-align complete (level, may be sticky)
//  bit_align_fail     input   1  bit-align failed (level)
//  burst_align_start  output  1  one-cycle pulse to burst-align stage
//  burst_align_done   input   1  burst-align complete (sticky level; constant 1 when that stage is bypassed)
//  burst_align_fail   input   1  burst-align failed (level)
//  phy_rdy            output  1  calibration passed; user path may drive QDR
//  cal_fail           output  1  calibration failed (sticky until reset)
//  phy_state          output  3  current state encoding, for debug
// BEHAVIOUR
//  - All outputs registered. Reset values: qdr_dll_off_n=0, both starts=0, phy_rdy=0, cal_fail=0,
//    phy_state=IDLE(0), counter=0. Reset mid-sequence returns to IDLE the following cycle,
//    with no start pulse emitted.
//  - States and encoding:
//    IDLE=0, DLL_WAIT=1, BIT_START=2, BIT_WAIT=3, BURST_START=4, BURST_WAIT=5, READY=6, FAIL=7.
//  - IDLE: phy_start=1 at cycle N -> DLL_WAIT and qdr_dll_off_n=1 at N+1. Counter loads DLL_WAIT_CYCLES-1.
//  - DLL_WAIT: decrement each cycle. At counter==0 go to BIT_START, giving exactly DLL_WAIT_CYCLES cycles in DLL_WAIT.
//  - BIT_START: bit_align_start=1 for exactly this one cycle. Load TIMEOUT_CYCLES-1, then go to BIT_WAIT.
//  - BIT_WAIT: done/fail are sampled starting the first cycle in this state.
//    Precedence is fail > done > timeout:
//    fail -> FAIL; done -> BURST_START; counter==0 -> FAIL; else decrement.
//  - BURST_START / BURST_WAIT: identical rules using the burst_align_* signals. Done -> READY.
//    A bypassed burst stage (done=1 constantly) reaches READY 2 cycles after BURST_START.
//  - READY: phy_rdy=1, terminal. FAIL: cal_fail=1, terminal.
//    phy_start is ignored in both; recalibration requires reset, because downstream done flags are sticky.
//  - qdr_dll_off_n stays 1 in every state except IDLE. It remains 1 in FAIL.
//  - Undefined encodings are unreachable. If one is ever decoded, go to FAIL.
//  - phy_start held high is harmless; it is only acted on in IDLE.
// STRUCTURE
//  - Shared header qdrc_phy_defs.vh: state localparams (QDRC_PHY_ST_*), the 3-bit state width,
//    and the default DLL_WAIT_CYCLES.
//  - Sub-module qdrc_phy_timer: loadable CNT_WIDTH down-counter with load/en/zero ports.
//    A single instance serves both the DLL wait and the stage timeouts.
//  - Remaining logic is the state register, next-state block and registered output decode.
// TESTING
//  1. Reset, phy_start at cycle 10, DLL_WAIT_CYCLES=16, both stages done 3 cycles after their start
//     -> dll_off_n rises at cycle 11; bit_align_start at cycle 27; phy_rdy=1; cal_fail=0; each start pulses once.
//  2. Bypassed burst stage (burst_align_done tied 1) -> phy_rdy exactly 2 cycles after burst_align_start.
//  3. bit_align_fail=1 with done=1 in the same cycle -> FAIL, cal_fail=1, burst_align_start never pulses.
//  4. TIMEOUT_CYCLES=8, burst stage never responds
//     -> FAIL entered 8 cycles after entering BURST_WAIT; phy_rdy stays 0.
//  5. Reset asserted in BIT_WAIT -> next cycle all outputs at reset values.
//     A new phy_start then reruns the full sequence.
//  6. phy_start pulsed while in READY and while in FAIL -> state, phy_rdy and cal_fail unchanged.

Source files
------------

// File: rtl/qdrc_phy_sequencer_pkg.sv
// Shared definitions for the QDR PHY calibration sequencer: state encoding,
// state width and the default DLL settle time.
package qdrc_phy_sequencer_pkg;

  localparam int unsigned PHY_STATE_W             = 3;
  localparam int unsigned DLL_WAIT_CYCLES_DEFAULT = 2048;

  typedef enum logic [PHY_STATE_W-1:0] {
    ST_IDLE        = 3'd0,
    ST_DLL_WAIT    = 3'd1,
    ST_BIT_START   = 3'd2,
    ST_BIT_WAIT    = 3'd3,
    ST_BURST_START = 3'd4,
    ST_BURST_WAIT  = 3'd5,
    ST_READY       = 3'd6,
    ST_FAIL        = 3'd7
  } phy_state_e;

endpackage

// File: rtl/qdrc_phy_timer.sv
// Loadable down-counter shared by the DLL settle wait and the per-stage timeouts.
// Holds at zero once reached; load takes priority over decrement.
module qdrc_phy_timer #(
  parameter int unsigned CNT_WIDTH = 17
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_value,
  input  logic                 en,
  output logic                 zero
);

  logic [CNT_WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - CNT_WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/qdrc_phy_sequencer.sv
// QDR PHY calibration sequencer: DLL release, bit alignment, burst alignment,
// then a terminal READY or FAIL. All outputs are registered.
module qdrc_phy_sequencer
  import qdrc_phy_sequencer_pkg::*;
#(
  parameter int unsigned DLL_WAIT_CYCLES = DLL_WAIT_CYCLES_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES  = 65536,
  parameter int unsigned CNT_WIDTH       = 17
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   phy_start,
  output logic                   qdr_dll_off_n,
  output logic                   bit_align_start,
  input  logic                   bit_align_done,
  input  logic                   bit_align_fail,
  output logic                   burst_align_start,
  input  logic                   burst_align_done,
  input  logic                   burst_align_fail,
  output logic                   phy_rdy,
  output logic                   cal_fail,
  output logic [PHY_STATE_W-1:0] phy_state
);

  localparam logic [CNT_WIDTH-1:0] DLL_LOAD = CNT_WIDTH'(DLL_WAIT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TMO_LOAD = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  phy_state_e           state, state_nxt;
  logic                 tmr_load, tmr_en, tmr_zero;
  logic [CNT_WIDTH-1:0] tmr_value;
  logic                 dll_on_nxt, bit_start_nxt, burst_start_nxt, rdy_nxt, fail_nxt;

  qdrc_phy_timer #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .en         (tmr_en),
    .zero       (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= ST_IDLE;
      qdr_dll_off_n     <= 1'b0;
      bit_align_start   <= 1'b0;
      burst_align_start <= 1'b0;
      phy_rdy           <= 1'b0;
      cal_fail          <= 1'b0;
    end else begin
      state             <= state_nxt;
      qdr_dll_off_n     <= dll_on_nxt;
      bit_align_start   <= bit_start_nxt;
      burst_align_start <= burst_start_nxt;
      phy_rdy           <= rdy_nxt;
      cal_fail          <= fail_nxt;
    end
  end

  // Within each *_WAIT state the priority is fail, then done, then timeout.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_value = '0;
    tmr_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (phy_start) begin
          state_nxt = ST_DLL_WAIT;
          tmr_load  = 1'b1;
          tmr_value = DLL_LOAD;
        end
      end
      ST_DLL_WAIT: begin
        tmr_en = 1'b1;
        if (tmr_zero) state_nxt = ST_BIT_START;
      end
      ST_BIT_START: begin
        state_nxt = ST_BIT_WAIT;
        tmr_load  = 1'b1;
        tmr_value = TMO_LOAD;
      end
      ST_BIT_WAIT: begin
        tmr_en = 1'b1;
        if (bit_align_fail)      state_nxt = ST_FAIL;
        else if (bit_align_done) state_nxt = ST_BURST_START;
        else if (tmr_zero)       state_nxt = ST_FAIL;
      end
      ST_BURST_START: begin
        state_nxt = ST_BURST_WAIT;
        tmr_load  = 1'b1;
        tmr_value = TMO_LOAD;
      end
      ST_BURST_WAIT: begin
        tmr_en = 1'b1;
        if (burst_align_fail)      state_nxt = ST_FAIL;
        else if (burst_align_done) state_nxt = ST_READY;
        else if (tmr_zero)         state_nxt = ST_FAIL;
      end
      ST_READY: state_nxt = ST_READY;
      ST_FAIL:  state_nxt = ST_FAIL;
      default:  state_nxt = ST_FAIL;
    endcase
  end

  // Outputs decode the next state so they register in step with the state itself.
  always_comb begin
    dll_on_nxt      = (state_nxt != ST_IDLE);
    bit_start_nxt   = (state_nxt == ST_BIT_START);
    burst_start_nxt = (state_nxt == ST_BURST_START);
    rdy_nxt         = (state_nxt == ST_READY);
    fail_nxt        = (state_nxt == ST_FAIL);
  end

  assign phy_state = state;

endmodule

// File: tb/tb_qdrc_phy_sequencer.sv
// Bench for qdrc_phy_sequencer: scenario tasks queue expected output events with
// their cycle numbers; a negedge monitor pops and checks them as the DUT emits them.
module tb_qdrc_phy_sequencer;

  localparam int EV_DLL   = 0;
  localparam int EV_BIT   = 1;
  localparam int EV_BURST = 2;
  localparam int EV_RDY   = 3;
  localparam int EV_FAIL  = 4;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       phy_start = 1'b0;
  logic       qdr_dll_off_n;
  logic       bit_align_start;
  logic       bit_align_done = 1'b0;
  logic       bit_align_fail = 1'b0;
  logic       burst_align_start;
  logic       burst_align_done = 1'b0;
  logic       burst_align_fail = 1'b0;
  logic       phy_rdy;
  logic       cal_fail;
  logic [2:0] phy_state;

  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;
  ev_t exp_q[$];

  logic       prev_dll = 1'b0, prev_rdy = 1'b0, prev_fail = 1'b0;
  logic [4:0] ev;

  qdrc_phy_sequencer #(
    .DLL_WAIT_CYCLES (16),
    .TIMEOUT_CYCLES  (8),
    .CNT_WIDTH       (17)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .phy_start         (phy_start),
    .qdr_dll_off_n     (qdr_dll_off_n),
    .bit_align_start   (bit_align_start),
    .bit_align_done    (bit_align_done),
    .bit_align_fail    (bit_align_fail),
    .burst_align_start (burst_align_start),
    .burst_align_done  (burst_align_done),
    .burst_align_fail  (burst_align_fail),
    .phy_rdy           (phy_rdy),
    .cal_fail          (cal_fail),
    .phy_state         (phy_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string ev_name(input int k);
    case (k)
      EV_DLL:   return "dll_on";
      EV_BIT:   return "bit_start";
      EV_BURST: return "burst_start";
      EV_RDY:   return "phy_rdy";
      default:  return "cal_fail";
    endcase
  endfunction

  assign ev = {cal_fail === 1'b1 && prev_fail !== 1'b1,
               phy_rdy === 1'b1 && prev_rdy !== 1'b1,
               burst_align_start === 1'b1,
               bit_align_start === 1'b1,
               qdr_dll_off_n === 1'b1 && prev_dll !== 1'b1};

  always @(negedge clk) begin
    for (int k = 0; k < 5; k++) begin
      if (ev[k]) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL event_unexpected: got %s at cycle %0d, required no event", ev_name(k), cyc);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          if (e.kind !== k || e.cyc !== cyc) begin
            miscompares++;
            $display("FAIL event_%s: got %s at cycle %0d, required %s at cycle %0d",
                     ev_name(e.kind), ev_name(k), cyc, ev_name(e.kind), e.cyc);
          end
        end
      end
    end
    prev_dll  <= qdr_dll_off_n;
    prev_rdy  <= phy_rdy;
    prev_fail <= cal_fail;
  end

  task automatic at_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset            = 1'b1;
    phy_start        = 1'b0;
    bit_align_done   = 1'b0;
    bit_align_fail   = 1'b0;
    burst_align_done = 1'b0;
    burst_align_fail = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic launch(output int s);
    @(posedge clk);
    #1;
    s         = cyc;
    phy_start = 1'b1;
    exp_q.push_back('{EV_DLL, s + 1});
    exp_q.push_back('{EV_BIT, s + 17});
    @(posedge clk);
    #1;
    phy_start = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++; if (qdr_dll_off_n !== 1'b0) begin miscompares++; $display("FAIL reset_dll_off_n: got %b, required 0", qdr_dll_off_n); end
    vectors++; if (bit_align_start !== 1'b0) begin miscompares++; $display("FAIL reset_bit_start: got %b, required 0", bit_align_start); end
    vectors++; if (burst_align_start !== 1'b0) begin miscompares++; $display("FAIL reset_burst_start: got %b, required 0", burst_align_start); end
    vectors++; if (phy_rdy !== 1'b0) begin miscompares++; $display("FAIL reset_phy_rdy: got %b, required 0", phy_rdy); end
    vectors++; if (cal_fail !== 1'b0) begin miscompares++; $display("FAIL reset_cal_fail: got %b, required 0", cal_fail); end
    vectors++; if (phy_state !== 3'd0) begin miscompares++; $display("FAIL reset_state: got %0d, required 0", phy_state); end
    reset = 1'b0;
  endtask

  task automatic test_nominal(input bit apply_reset);
    int s;
    if (apply_reset) do_reset();
    launch(s);
    exp_q.push_back('{EV_BURST, s + 21});
    exp_q.push_back('{EV_RDY, s + 25});
    at_cycle(s + 20);
    bit_align_done = 1'b1;
    at_cycle(s + 24);
    burst_align_done = 1'b1;
    at_cycle(s + 30);
    @(negedge clk);
    vectors++; if (phy_rdy !== 1'b1) begin miscompares++; $display("FAIL nominal_phy_rdy: got %b, required 1", phy_rdy); end
    vectors++; if (cal_fail !== 1'b0) begin miscompares++; $display("FAIL nominal_cal_fail: got %b, required 0", cal_fail); end
    vectors++; if (phy_state !== 3'd6) begin miscompares++; $display("FAIL nominal_state: got %0d, required 6", phy_state); end
    vectors++; if (qdr_dll_off_n !== 1'b1) begin miscompares++; $display("FAIL nominal_dll_off_n: got %b, required 1", qdr_dll_off_n); end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL nominal_events: %0d events missing, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_bypass();
    int s;
    do_reset();
    burst_align_done = 1'b1;
    launch(s);
    exp_q.push_back('{EV_BURST, s + 21});
    exp_q.push_back('{EV_RDY, s + 23});
    at_cycle(s + 20);
    bit_align_done = 1'b1;
    at_cycle(s + 28);
    @(negedge clk);
    vectors++; if (phy_state !== 3'd6) begin miscompares++; $display("FAIL bypass_state: got %0d, required 6", phy_state); end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL bypass_events: %0d events missing, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_bit_fail();
    int s;
    do_reset();
    launch(s);
    exp_q.push_back('{EV_FAIL, s + 21});
    at_cycle(s + 20);
    bit_align_done = 1'b1;
    bit_align_fail = 1'b1;
    at_cycle(s + 35);
    @(negedge clk);
    vectors++; if (cal_fail !== 1'b1) begin miscompares++; $display("FAIL bitfail_cal_fail: got %b, required 1", cal_fail); end
    vectors++; if (phy_rdy !== 1'b0) begin miscompares++; $display("FAIL bitfail_phy_rdy: got %b, required 0", phy_rdy); end
    vectors++; if (phy_state !== 3'd7) begin miscompares++; $display("FAIL bitfail_state: got %0d, required 7", phy_state); end
    vectors++; if (qdr_dll_off_n !== 1'b1) begin miscompares++; $display("FAIL bitfail_dll_off_n: got %b, required 1", qdr_dll_off_n); end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL bitfail_events: %0d events missing, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_timeout();
    int s;
    do_reset();
    launch(s);
    exp_q.push_back('{EV_BURST, s + 21});
    exp_q.push_back('{EV_FAIL, s + 30});
    at_cycle(s + 20);
    bit_align_done = 1'b1;
    at_cycle(s + 40);
    @(negedge clk);
    vectors++; if (phy_rdy !== 1'b0) begin miscompares++; $display("FAIL timeout_phy_rdy: got %b, required 0", phy_rdy); end
    vectors++; if (phy_state !== 3'd7) begin miscompares++; $display("FAIL timeout_state: got %0d, required 7", phy_state); end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL timeout_events: %0d events missing, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_reset_midseq();
    int s;
    do_reset();
    launch(s);
    at_cycle(s + 19);
    @(negedge clk);
    vectors++; if (phy_state !== 3'd3) begin miscompares++; $display("FAIL midseq_pre_state: got %0d, required 3", phy_state); end
    reset = 1'b1;
    at_cycle(s + 20);
    @(negedge clk);
    vectors++; if (phy_state !== 3'd0) begin miscompares++; $display("FAIL midseq_state: got %0d, required 0", phy_state); end
    vectors++; if (qdr_dll_off_n !== 1'b0) begin miscompares++; $display("FAIL midseq_dll_off_n: got %b, required 0", qdr_dll_off_n); end
    vectors++; if ({bit_align_start, burst_align_start, phy_rdy, cal_fail} !== 4'b0000) begin
      miscompares++;
      $display("FAIL midseq_outputs: got %b, required 0000", {bit_align_start, burst_align_start, phy_rdy, cal_fail});
    end
    reset = 1'b0;
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL midseq_events: %0d events missing, required 0", exp_q.size()); exp_q.delete(); end
    test_nominal(1'b0);
  endtask

  task automatic test_ignore_start();
    test_nominal(1'b1);
    phy_start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    phy_start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if ({phy_state, phy_rdy, cal_fail} !== {3'd6, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL ignore_ready: got state %0d rdy %b fail %b, required state 6 rdy 1 fail 0", phy_state, phy_rdy, cal_fail);
    end
    test_bit_fail();
    phy_start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    phy_start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if ({phy_state, phy_rdy, cal_fail} !== {3'd7, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL ignore_fail: got state %0d rdy %b fail %b, required state 7 rdy 0 fail 1", phy_state, phy_rdy, cal_fail);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_nominal(1'b1);
    test_bypass();
    test_bit_fail();
    test_timeout();
    test_reset_midseq();
    test_ignore_start();
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
